stream_byte_packer: RTL
=======================

Name: stream_byte_packer

Overview:
- Upstream stage that packs a byte-wide valid/ready stream into wide words for the sample stage's 8-bit and 64-bit data inputs.
- Accumulates BYTES input bytes, little-endian, into one output word.
- A packet may end early on in_last; the partial word is then emitted with a byte-enable mask.
- Single clock domain; one registered output slot; full-throughput handshake.

Parameters:
BYTES, 8, bytes per output word; legal range 2..8.
CNT_W, 16, width of the emitted-word counter.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input byte valid
in_ready  output  1  input byte accepted when in_valid && in_ready
in_data  input  8  input byte
in_last  input  1  marks final byte of a packet
out_valid  output  1  output word valid
out_ready  input  1  downstream ready
out_data  output  8*BYTES  packed word; byte k at bits [8k+7:8k]
out_keep  output  BYTES  byte-enable; bit k set = byte k valid, always contiguous from bit 0
out_last  output  1  word holds the final byte of a packet
out_byte  output  8  byte 0 of out_data, for byte-wide consumers
words_out  output  CNT_W  count of words transferred (out_valid && out_ready); wraps

Behaviour:
- Reset (async assert; deassert sampled on clk):
  - out_valid=0, out_data=0, out_keep=0, out_last=0, words_out=0.
  - Accumulator index idx=0, accumulator data and mask cleared.
- in_ready = !out_valid || out_ready. It is combinational and never depends on in_valid or in_data.
- Accept byte, no completion (idx<BYTES-1 and in_last=0):
  - acc byte[idx] <= in_data; mask bit idx set; idx <= idx+1.
- Accept byte, completion (idx==BYTES-1 or in_last=1):
  - Word {in_data placed at idx, acc} loads the output register the same edge.
  - out_keep = mask | (1<<idx); out_last = in_last.
  - out_valid <= 1; idx, acc and mask cleared.
  - Latency: completing byte accepted at edge N → out_valid high after edge N.
- Unused bytes in out_data (keep=0) are driven 0.
- Output transfer (out_valid && out_ready):
  - words_out += 1, wrapping 2^CNT_W-1 → 0.
  - If no completing byte is accepted the same edge, out_valid <= 0.
- Simultaneous transfer and completion on one edge:
  - New word replaces old one; out_valid stays 1; no bubble, so back-to-back words run at full rate.
- Backpressure:
  - out_valid=1 and out_ready=0 → in_ready=0; all input bytes stall, including non-completing ones.
  - out_* held stable until transfer.
- in_last at idx==BYTES-1 → one full word with last=1; no empty word follows.
- in_valid while in_ready=0 → nothing consumed; the upstream must hold in_data and in_last.
- Reset mid-packet or with out_valid=1: the partial accumulation and the pending word are discarded, with no output.

Test Plan:
- Reset, then bytes 0x11..0x88 with BYTES=8, in_last on 0x88, out_ready=1 → one word 0x8877665544332211, keep=0xFF, last=1, words_out=1, out_byte=0x11.
- Bytes 0xA1,0xA2,0xA3 with in_last on 0xA3 → out_data=0x0000000000A3A2A1, keep=0x07, last=1; the next packet starts at idx 0.
- 16 consecutive bytes, out_ready=1 constantly → two words on cycles N and N+8; in_ready never low.
- Complete a word with out_ready=0 for 5 cycles → in_ready=0 for those 5 cycles; out_data stable; the word transfers on the first cycle out_ready=1.
- Assert reset after 3 bytes accepted and with one word pending → out_valid=0 immediately; a following 8-byte packet yields exactly one word with keep=0xFF and words_out=1.
- CNT_W=2, transfer 5 single-byte packets → words_out sequence 1,2,3,0,1; each word has keep=0x01.

Source files
------------

// File: rtl/stream_byte_packer.sv
// Packs a byte-wide valid/ready stream into little-endian words of BYTES bytes.
// Packets may end early on in_last; the partial word then carries a keep mask.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   in_valid/in_ready      byte-stream handshake (in_ready is combinational)
//   in_data, in_last       input byte and end-of-packet marker
//   out_valid/out_ready    word-stream handshake
//   out_data, out_keep     packed word (byte k at [8k+7:8k]) and byte enables
//   out_last               word holds the final byte of a packet
//   out_byte               byte 0 of out_data, for byte-wide consumers
//   words_out              wrapping count of transferred words
module stream_byte_packer #(
    parameter int BYTES = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*BYTES-1:0] out_data,
    output logic [BYTES-1:0]   out_keep,
    output logic               out_last,
    output logic [7:0]         out_byte,
    output logic [CNT_W-1:0]   words_out
);

    localparam int IDX_W = $clog2(BYTES);
    localparam int W     = 8 * BYTES;

    logic [IDX_W-1:0] idx;
    logic [W-1:0]     acc;
    logic [BYTES-1:0] mask;

    logic             accept;
    logic             xfer;
    logic             complete;
    logic [W-1:0]     word_in;
    logic [BYTES-1:0] keep_in;

    // The single output slot can take a new word whenever it is empty or
    // is being drained this same edge, so a full stream never bubbles.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign complete = accept && (in_last || idx == IDX_W'(BYTES - 1));

    // Bytes above idx in acc are always zero, so OR-ing in the new byte
    // both inserts it and leaves unused lanes cleared.
    assign word_in  = W'(in_data) << {idx, 3'b000};
    assign keep_in  = BYTES'(1) << idx;

    assign out_byte = out_data[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            acc       <= '0;
            mask      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            words_out <= '0;
        end else begin
            if (xfer) begin
                words_out <= words_out + CNT_W'(1);
                out_valid <= 1'b0;
            end
            if (complete) begin
                out_valid <= 1'b1;
                out_data  <= acc | word_in;
                out_keep  <= mask | keep_in;
                out_last  <= in_last;
                acc       <= '0;
                mask      <= '0;
                idx       <= '0;
            end else if (accept) begin
                acc  <= acc | word_in;
                mask <= mask | keep_in;
                idx  <= idx + IDX_W'(1);
            end
        end
    end

endmodule
